cla4_seq_adder: RTL
===================

// Module: cla4_seq_adder
// PURPOSE
//  Sequencing controller that computes a (4*N_NIBBLES)-bit add, one nibble per clock,
//  through a single cla4 instance. Latches operands on start, iterates LSB-to-MSB nibble,
//  holds the carry in a register between nibbles, and reports the sum with a done pulse.
//  Sits between a requesting FSM/testbench and the shared 4-bit CLA datapath.
// PARAMETERS
//  N_NIBBLES  8   number of 4-bit slices; operand width W = 4*N_NIBBLES (N_NIBBLES >= 2)
// PORTS
//  clk    in   1   single clock, rising edge
//  reset  in   1   asynchronous, active-high reset
//  start  in   1   request; sampled only in IDLE or DONE
//  a      in   W   operand A, captured on accepted start
//  b      in   W   operand B, captured on accepted start
//  ci     in   1   carry-in to nibble 0, captured on accepted start
//  busy   out  1   1 while in EXEC
//  done   out  1   1-cycle pulse; s/co are valid from this cycle on
//  s      out  W   sum, held until the next accepted start
//  co     out  1   carry-out of the MSB nibble, held with s
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, carry reg=0, busy=0, done=0, s=0, co=0; any operation in progress is abandoned.
//  States: IDLE -start-> EXEC; EXEC -(idx==N_NIBBLES-1)-> DONE; DONE -start-> EXEC, else -> IDLE.
//  Accept (IDLE or DONE, start=1): latch a,b into op regs, carry<=ci, idx<=0, s<=0, co<=0.
//  EXEC, each cycle: cla4 gets a_r[4*idx+:4], b_r[4*idx+:4], carry; s[4*idx+:4]<=sum; carry<=cla4 co;
//   idx<=idx+1. On last nibble: co<=cla4 co, idx<=0, state<=DONE.
//  Latency: start sampled at edge t -> done=1 for the cycle after edge t+N_NIBBLES; back-to-back
//   start while done=1 is accepted (throughput one add per N_NIBBLES+1 cycles).
//  start during EXEC is ignored; a/b/ci changes after acceptance have no effect.
//  Arithmetic: unsigned modulo 2^W; {co,s} = a+b+ci exactly. idx width = $clog2(N_NIBBLES).
//  s bits of unprocessed nibbles read 0 during EXEC; only s at/after done is defined as the result.
//  Reset asserted mid-EXEC: immediate return to IDLE with all outputs cleared, no done pulse.
// CONFIGURATION
//  CLA4_SEQ_SUB_EN defined: extra ports  sub in 1 (captured with start)  and  ovf out 1.
//   sub=1: b_r <= ~b, carry <= 1 (ci ignored) -> s = a-b mod 2^W, co = 1 when no borrow.
//   ovf = signed overflow of the last nibble (carry into MSB xor co), valid/held like co, reset 0.
//  Undefined: sub/ovf ports absent; behaviour exactly the add-only description above.
// STRUCTURE
//  Shared package/include (cla4_seq_defs): state encodings IDLE=2'b00, EXEC=2'b01, DONE=2'b10;
//   default N_NIBBLES. Encoding 2'b11 is illegal -> next state IDLE.
//  One sub-module: a single cla4 instance (existing 4-bit CLA) as the nibble datapath; FSM,
//   index counter, carry register and result shift/insert stay in this module.
// TESTING (N_NIBBLES=8)
//  1 a=32'h0000_0001 b=32'hFFFF_FFFF ci=0 start -> busy 8 cycles, done pulse, s=0, co=1 (full carry ripple).
//  2 a=32'h1234_5678 b=32'h1111_1111 ci=1 -> s=32'h2345_678A, co=0; start pulsed mid-EXEC ignored.
//  3 two back-to-back starts (second while done=1): a=5,b=7 then a=32'hFFFF_FFFF,b=1 ->
//    s=12,co=0 then s=0,co=1; second done exactly 9 cycles after first.
//  4 reset asserted at 4th EXEC cycle -> busy/done/s/co = 0 at once; later start computes normally.
//  5 random 1000 vectors vs. {co,s}==a+b+ci reference model; done never asserts without start.
//  6 CLA4_SEQ_SUB_EN: a=5,b=7,sub=1 -> s=32'hFFFF_FFFE, co=0; a=32'h7FFF_FFFF,b=32'hFFFF_FFFF,sub=1 -> ovf=1.

Source files
------------

// File: rtl/cla4_seq_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and default slice count.
package cla4_seq_adder_pkg;
  localparam int DEF_N_NIBBLES = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/cla4_seq_adder_if.sv
// Request/result bus of the nibble-serial adder; sub/ovf exist only when CLA4_SEQ_SUB_EN is defined.
interface cla4_seq_adder_if #(parameter int N_NIBBLES = 8);
  localparam int W = 4 * N_NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
`ifdef CLA4_SEQ_SUB_EN
  logic         sub;
  logic         ovf;

  modport master (output start, a, b, ci, sub, input busy, done, s, co, ovf);
  modport slave  (input start, a, b, ci, sub, output busy, done, s, co, ovf);
`else
  modport master (output start, a, b, ci, input busy, done, s, co);
  modport slave  (input start, a, b, ci, output busy, done, s, co);
`endif
endinterface

// File: rtl/cla4_seq_adder_cla4.sv
// 4-bit carry-lookahead adder slice, purely combinational (zero latency, no handshake).
module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g  = a_i & b_i;
  assign p  = a_i ^ b_i;
  assign c1 = g[0] | (p[0] & ci_i);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci_i);
  assign co_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci_i);
  assign s_o  = p ^ {c3, c2, c1, ci_i};
endmodule

// File: rtl/cla4_seq_adder.sv
// Nibble-serial W-bit adder: one nibble per clock through a shared cla4; done pulses N_NIBBLES+1 cycles
// after start. start is ignored while busy. CLA4_SEQ_SUB_EN adds subtract mode and signed overflow.
module cla4_seq_adder
  import cla4_seq_adder_pkg::*;
#(
  parameter int N_NIBBLES = DEF_N_NIBBLES
) (
  input logic           clk,
  input logic           reset,
  cla4_seq_adder_if.slave bus
);
  localparam int IDX_W = $clog2(N_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      carry_q;
  logic [N_NIBBLES-1:0][3:0] a_q;
  logic [N_NIBBLES-1:0][3:0] b_q;
  logic [N_NIBBLES-1:0][3:0] s_q;
  logic [N_NIBBLES-1:0][3:0] s_d;
  logic                      co_q;
  logic                      busy_q;
  logic                      done_q;
  logic [3:0]                nib_a;
  logic [3:0]                nib_b;
  logic [3:0]                nib_s;
  logic                      nib_co;
`ifdef CLA4_SEQ_SUB_EN
  logic                      ovf_q;
`endif

  always_comb begin
    nib_a      = a_q[idx_q];
    nib_b      = b_q[idx_q];
    s_d        = s_q;
    s_d[idx_q] = nib_s;
  end

  cla4 u_cla4 (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .ci_i (carry_q),
    .s_o  (nib_s),
    .co_o (nib_co)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CLA4_SEQ_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            idx_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
`ifdef CLA4_SEQ_SUB_EN
            // Subtract as a + ~b + 1; ci is irrelevant in that mode.
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub | bus.ci;
            ovf_q   <= 1'b0;
`else
            b_q     <= bus.b;
            carry_q <= bus.ci;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          s_q     <= s_d;
          carry_q <= nib_co;
          if (idx_q == LAST_IDX) begin
            co_q    <= nib_co;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
`ifdef CLA4_SEQ_SUB_EN
            // Carry into the MSB recovered from the sum bit, xor'd with carry out.
            ovf_q   <= nib_a[3] ^ nib_b[3] ^ nib_s[3] ^ nib_co;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;
`ifdef CLA4_SEQ_SUB_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule
